top_module_pipe: RTL and testbench

- Top level of a 5-stage in-order RV32I-subset pipeline: IF, ID, EX, MEM, WB.
- Contains:
  - a 128x32 instruction memory with an external write (load) port;
  - a 32x32 register file;
  - a 128x32 data memory;
  - hazard logic for forwarding, load-use stall and branch flush.
- A bench loads a program through the write port while the PC is held, then releases the PC and lets the core run.

---
 rtl/top_module_pipe.sv | 233 +++++++++++++++++++++++
 tb/tb_top_module_pipe.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/top_module_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : top_module_pipe                                                |
// | Purpose : 5-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with a     |
// |           loadable 128x32 instruction memory, 32x32 register file,       |
// |           128x32 data memory, EX-stage forwarding, load-use stall and     |
// |           branch/jump flush.                                             |
// | Ports   : clk         - rising-edge clock                                |
// |           reset       - asynchronous active-low reset                    |
// |           resetpc     - 0 holds PC at 0 and feeds bubbles, 1 runs        |
// |           we0/wr_addr0/wr_din0 - instruction memory write port           |
// |           dbg_pc      - IF-stage PC                                      |
// |           dbg_wb_en/dbg_wb_rd/dbg_wb_data - register file write in WB    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module top_module_pipe #(
   parameter int IMEM_WORDS = 128,
   parameter int DMEM_WORDS = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        resetpc,
   input  logic        we0,
   input  logic [8:0]  wr_addr0,
   input  logic [31:0] wr_din0,
   output logic [31:0] dbg_pc,
   output logic        dbg_wb_en,
   output logic [4:0]  dbg_wb_rd,
   output logic [31:0] dbg_wb_data
);
   localparam int IA_W = $clog2(IMEM_WORDS);
   localparam int DA_W = $clog2(DMEM_WORDS);
   localparam logic [31:0] NOP = 32'h0000_0013;   // addi x0,x0,0
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011;

   // pipeline state
   logic [31:0] pc_q, pc_d, ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d;
   logic [31:0] idex_instr_q, idex_instr_d, idex_pc_q, idex_pc_d;
   logic [31:0] idex_rs1v_q, idex_rs1v_d, idex_rs2v_q, idex_rs2v_d;
   logic [31:0] exmem_res_q, exmem_res_d, exmem_sdata_q, exmem_sdata_d;
   logic [4:0]  exmem_rd_q, exmem_rd_d, memwb_rd_q, memwb_rd_d;
   logic        exmem_wen_q, exmem_wen_d, exmem_mwe_q, exmem_mwe_d, exmem_load_q, exmem_load_d;
   logic        memwb_en_q, memwb_en_d;
   logic [31:0] memwb_data_q, memwb_data_d;

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] rf_q [32];
   logic [31:0] dmem_q [DMEM_WORDS];

   // ---------------- instruction memory (not cleared by reset) ----------------
   always_ff @(posedge clk) begin
      if (we0) imem[wr_addr0[IA_W+1:2]] <= wr_din0;
   end
   logic [31:0] fetch_instr;
   assign fetch_instr = imem[pc_q[IA_W+1:2]];

   // ---------------- ID: register read with WB write-through ----------------
   logic [4:0]  id_rs1, id_rs2;
   logic [31:0] id_rs1v, id_rs2v;
   assign id_rs1  = ifid_instr_q[19:15];
   assign id_rs2  = ifid_instr_q[24:20];
   // memwb_en_q already implies rd != 0, so x0 can never be bypassed
   assign id_rs1v = (memwb_en_q && memwb_rd_q == id_rs1) ? memwb_data_q : rf_q[id_rs1];
   assign id_rs2v = (memwb_en_q && memwb_rd_q == id_rs2) ? memwb_data_q : rf_q[id_rs2];

   // ---------------- EX ----------------
   function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                       input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (f3)
         3'b000:  r = alt ? a - b : a + b;
         3'b001:  r = a << b[4:0];
         3'b010:  r = {31'd0, $signed(a) < $signed(b)};
         3'b011:  r = {31'd0, a < b};
         3'b100:  r = a ^ b;
         3'b101:  r = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   logic [6:0]  ex_op, ex_f7;
   logic [2:0]  ex_f3;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] ex_a, ex_b, ex_res, ex_target;
   logic        ex_wen, ex_mwe, ex_load, ex_taken, ex_redirect, load_use;

   assign ex_op  = idex_instr_q[6:0];
   assign ex_rd  = idex_instr_q[11:7];
   assign ex_f3  = idex_instr_q[14:12];
   assign ex_rs1 = idex_instr_q[19:15];
   assign ex_rs2 = idex_instr_q[24:20];
   assign ex_f7  = idex_instr_q[31:25];
   assign imm_i  = {{20{idex_instr_q[31]}}, idex_instr_q[31:20]};
   assign imm_s  = {{20{idex_instr_q[31]}}, idex_instr_q[31:25], idex_instr_q[11:7]};
   assign imm_b  = {{19{idex_instr_q[31]}}, idex_instr_q[31], idex_instr_q[7],
                    idex_instr_q[30:25], idex_instr_q[11:8], 1'b0};
   assign imm_u  = {idex_instr_q[31:12], 12'd0};
   assign imm_j  = {{11{idex_instr_q[31]}}, idex_instr_q[31], idex_instr_q[19:12],
                    idex_instr_q[20], idex_instr_q[30:21], 1'b0};

   always_comb begin
      // operand forwarding: EX/MEM beats MEM/WB beats the ID/EX copy
      ex_a = idex_rs1v_q;
      if (exmem_wen_q && exmem_rd_q == ex_rs1)     ex_a = exmem_res_q;
      else if (memwb_en_q && memwb_rd_q == ex_rs1) ex_a = memwb_data_q;
      ex_b = idex_rs2v_q;
      if (exmem_wen_q && exmem_rd_q == ex_rs2)     ex_b = exmem_res_q;
      else if (memwb_en_q && memwb_rd_q == ex_rs2) ex_b = memwb_data_q;

      ex_res = '0; ex_wen = 1'b0; ex_mwe = 1'b0; ex_load = 1'b0;
      ex_taken = 1'b0; ex_redirect = 1'b0; ex_target = '0;
      case (ex_op)
         OP_OP: if (ex_f7 == 7'd0 || (ex_f7 == 7'b0100000 && (ex_f3 == 3'b000 || ex_f3 == 3'b101))) begin
            ex_wen = 1'b1; ex_res = alu(ex_f3, ex_f7[5], ex_a, ex_b);
         end
         OP_IMM: if ((ex_f3 == 3'b001) ? (ex_f7 == 7'd0)
                     : (ex_f3 != 3'b101 || ex_f7 == 7'd0 || ex_f7 == 7'b0100000)) begin
            // only the shift-right form uses bit 30 as the arithmetic select
            ex_wen = 1'b1; ex_res = alu(ex_f3, (ex_f3 == 3'b101) & ex_f7[5], ex_a, imm_i);
         end
         OP_LOAD:  if (ex_f3 == 3'b010) begin ex_wen = 1'b1; ex_load = 1'b1; ex_res = ex_a + imm_i; end
         OP_STORE: if (ex_f3 == 3'b010) begin ex_mwe = 1'b1; ex_res = ex_a + imm_s; end
         OP_BRANCH: begin
            case (ex_f3)
               3'b000:  ex_taken = (ex_a == ex_b);
               3'b001:  ex_taken = (ex_a != ex_b);
               3'b100:  ex_taken = ($signed(ex_a) <  $signed(ex_b));
               3'b101:  ex_taken = ($signed(ex_a) >= $signed(ex_b));
               3'b110:  ex_taken = (ex_a <  ex_b);
               3'b111:  ex_taken = (ex_a >= ex_b);
               default: ex_taken = 1'b0;
            endcase
            ex_redirect = ex_taken; ex_target = idex_pc_q + imm_b;
         end
         OP_JAL: begin
            ex_wen = 1'b1; ex_res = idex_pc_q + 32'd4; ex_redirect = 1'b1; ex_target = idex_pc_q + imm_j;
         end
         OP_JALR: if (ex_f3 == 3'b000) begin
            ex_wen = 1'b1; ex_res = idex_pc_q + 32'd4; ex_redirect = 1'b1;
            ex_target = (ex_a + imm_i) & ~32'd1;
         end
         OP_LUI:   begin ex_wen = 1'b1; ex_res = imm_u; end
         OP_AUIPC: begin ex_wen = 1'b1; ex_res = idex_pc_q + imm_u; end
         default: ;
      endcase
      // x0 writes are dropped here so every later stage can treat wen as "real write"
      if (ex_rd == 5'd0) ex_wen = 1'b0;
   end

   assign load_use = (ex_op == OP_LOAD) && (ex_f3 == 3'b010) && (ex_rd == id_rs1 || ex_rd == id_rs2);

   // ---------------- MEM ----------------
   logic [31:0] mem_rdata;
   assign mem_rdata = dmem_q[exmem_res_q[DA_W+1:2]];

   // ---------------- next-state ----------------
   always_comb begin
      pc_d         = pc_q + 32'd4;
      ifid_instr_d = fetch_instr;
      ifid_pc_d    = pc_q;
      idex_instr_d = ifid_instr_q;
      idex_pc_d    = ifid_pc_q;
      idex_rs1v_d  = id_rs1v;
      idex_rs2v_d  = id_rs2v;
      if (ex_redirect) begin
         pc_d = ex_target; ifid_instr_d = NOP; idex_instr_d = NOP;
      end else if (load_use) begin
         pc_d = pc_q; ifid_instr_d = ifid_instr_q; ifid_pc_d = ifid_pc_q; idex_instr_d = NOP;
      end
      // run-enable low overrides everything on the fetch side; older work drains
      if (!resetpc) begin
         pc_d = '0; ifid_instr_d = NOP;
      end
      exmem_res_d   = ex_res;
      exmem_sdata_d = ex_b;
      exmem_rd_d    = ex_rd;
      exmem_wen_d   = ex_wen;
      exmem_mwe_d   = ex_mwe;
      exmem_load_d  = ex_load;
      memwb_en_d    = exmem_wen_q;
      memwb_rd_d    = exmem_rd_q;
      memwb_data_d  = exmem_load_q ? mem_rdata : exmem_res_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= '0; ifid_instr_q <= NOP; ifid_pc_q <= '0;
         idex_instr_q <= NOP; idex_pc_q <= '0; idex_rs1v_q <= '0; idex_rs2v_q <= '0;
         exmem_res_q <= '0; exmem_sdata_q <= '0; exmem_rd_q <= '0;
         exmem_wen_q <= 1'b0; exmem_mwe_q <= 1'b0; exmem_load_q <= 1'b0;
         memwb_en_q <= 1'b0; memwb_rd_q <= '0; memwb_data_q <= '0;
      end else begin
         pc_q <= pc_d; ifid_instr_q <= ifid_instr_d; ifid_pc_q <= ifid_pc_d;
         idex_instr_q <= idex_instr_d; idex_pc_q <= idex_pc_d;
         idex_rs1v_q <= idex_rs1v_d; idex_rs2v_q <= idex_rs2v_d;
         exmem_res_q <= exmem_res_d; exmem_sdata_q <= exmem_sdata_d; exmem_rd_q <= exmem_rd_d;
         exmem_wen_q <= exmem_wen_d; exmem_mwe_q <= exmem_mwe_d; exmem_load_q <= exmem_load_d;
         memwb_en_q <= memwb_en_d; memwb_rd_q <= memwb_rd_d; memwb_data_q <= memwb_data_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (memwb_en_q) begin
         rf_q[memwb_rd_q] <= memwb_data_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
      end else if (exmem_mwe_q) begin
         dmem_q[exmem_res_q[DA_W+1:2]] <= exmem_sdata_q;
      end
   end

   assign dbg_pc      = pc_q;
   assign dbg_wb_en   = memwb_en_q;
   assign dbg_wb_rd   = memwb_rd_q;
   assign dbg_wb_data = memwb_data_q;

   // address bits outside the word index are intentionally ignored
   logic unused_bits;
   assign unused_bits = ^{wr_addr0[1:0], pc_q[31:IA_W+2], pc_q[1:0],
                          exmem_res_q[31:DA_W+2], exmem_res_q[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_top_module_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_top_module_pipe                                             |
// | Purpose : scoreboard bench for top_module_pipe; directed programs push    |
// |           expected register writebacks, a monitor pops and compares.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_top_module_pipe;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        resetpc = 1'b0;
   logic        we0 = 1'b0;
   logic [8:0]  wr_addr0 = '0;
   logic [31:0] wr_din0 = '0;
   logic [31:0] dbg_pc;
   logic        dbg_wb_en;
   logic [4:0]  dbg_wb_rd;
   logic [31:0] dbg_wb_data;

   top_module_pipe dut (
      .clk(clk), .reset(reset), .resetpc(resetpc), .we0(we0),
      .wr_addr0(wr_addr0), .wr_din0(wr_din0), .dbg_pc(dbg_pc),
      .dbg_wb_en(dbg_wb_en), .dbg_wb_rd(dbg_wb_rd), .dbg_wb_data(dbg_wb_data)
   );

   always #10 clk = ~clk;

   typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;
   wb_t         exp_q[$];
   int          wb_cyc[$];
   logic [31:0] prog[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          cyc = 0;
   wb_t         mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: every register file write must match the head of the queue
   always @(negedge clk) begin
      if (reset && dbg_wb_en) begin
         wb_cyc.push_back(cyc);
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL wb_unexpected: actual x%0d=0x%08h, required no write", dbg_wb_rd, dbg_wb_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (dbg_wb_rd !== mon_e.rd || dbg_wb_data !== mon_e.data) begin
               tests_failed++;
               $display("FAIL wb_value: actual x%0d=0x%08h, required x%0d=0x%08h",
                        dbg_wb_rd, dbg_wb_data, mon_e.rd, mon_e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data);
      exp_q.push_back('{rd: rd, data: data});
   endtask

   task automatic do_reset();
      @(posedge clk); #2 reset = 1'b0;
      @(posedge clk); #2 reset = 1'b1;
   endtask

   // loads prog[] at byte 0,4,...; PC and WB must stay idle while held
   task automatic load_prog();
      for (int i = 0; i < prog.size(); i++) begin
         @(posedge clk); #2;
         we0 = 1'b1; wr_addr0 = 9'(i * 4); wr_din0 = prog[i];
         #6;
         check("hold_pc", dbg_pc, 32'd0);
         check("hold_wb_en", {31'd0, dbg_wb_en}, 32'd0);
      end
      @(posedge clk); #2 we0 = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         @(posedge clk); n++;
      end
      repeat (12) @(posedge clk);       // window to catch stray writes
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      #2 resetpc = 1'b0;
      repeat (6) @(posedge clk);
   endtask

   task automatic run_prog();
      wb_cyc.delete();
      @(posedge clk); #2 resetpc = 1'b1;
      wait_done();
   endtask

   initial begin
      #5;
      check("rst_pc", dbg_pc, 32'd0);
      check("rst_wb_en", {31'd0, dbg_wb_en}, 32'd0);
      check("rst_wb_rd", {27'd0, dbg_wb_rd}, 32'd0);
      check("rst_wb_data", dbg_wb_data, 32'd0);
      #20 reset = 1'b1;

      // fill the whole instruction memory with NOPs
      for (int i = 0; i < 128; i++) begin
         @(posedge clk); #2 we0 = 1'b1; wr_addr0 = 9'(i * 4); wr_din0 = 32'h0000_0013;
      end
      @(posedge clk); #2 we0 = 1'b0;

      // forwarding chain (+ halt), also the load-and-hold check
      do_reset();
      prog = '{32'h0050_0093, 32'h0030_8113, 32'h0020_81B3, 32'h4011_8233, 32'h0000_006F, 32'h0000_0013};
      load_prog();
      expect_wb(5'd1, 32'd5); expect_wb(5'd2, 32'd8); expect_wb(5'd3, 32'd13); expect_wb(5'd4, 32'd8);
      run_prog();
      check("fwd_wb_count", 32'(wb_cyc.size()), 32'd4);
      for (int i = 0; i + 1 < wb_cyc.size(); i++)
         check("fwd_no_stall_gap", 32'(wb_cyc[i+1] - wb_cyc[i]), 32'd1);

      // load-use stall
      do_reset();
      prog = '{32'h02A0_0093, 32'h0010_2423, 32'h0080_2103, 32'h0011_0193, 32'h0000_006F};
      load_prog();
      expect_wb(5'd1, 32'd42); expect_wb(5'd2, 32'd42); expect_wb(5'd3, 32'd43);
      run_prog();
      check("lu_wb_count", 32'(wb_cyc.size()), 32'd3);
      if (wb_cyc.size() >= 3) check("lu_one_bubble_gap", 32'(wb_cyc[2] - wb_cyc[1]), 32'd2);

      // branch flush: x5 must never be written
      do_reset();
      prog = '{32'h0010_0093, 32'h0010_8463, 32'h0630_0293, 32'h0070_0313, 32'h0000_006F};
      load_prog();
      expect_wb(5'd1, 32'd1); expect_wb(5'd6, 32'd7);
      run_prog();

      // jal x1,+8 ; jalr x0,0(x1) ; addi x7,x0,3 ; j -8  (jalr then loops on itself)
      do_reset();
      prog = '{32'h0080_00EF, 32'h0000_8067, 32'h0030_0393, 32'hFF9F_F06F};
      load_prog();
      expect_wb(5'd1, 32'd4); expect_wb(5'd7, 32'd3);
      run_prog();

      // asynchronous reset mid-run, then rerun from the preserved imem
      do_reset();
      expect_wb(5'd1, 32'd4); expect_wb(5'd7, 32'd3);
      @(posedge clk); #2 resetpc = 1'b1;
      repeat (3) @(posedge clk);
      #5 reset = 1'b0;
      #1;
      check("async_rst_pc", dbg_pc, 32'd0);
      check("async_rst_wb_en", {31'd0, dbg_wb_en}, 32'd0);
      check("async_rst_wb_data", dbg_wb_data, 32'd0);
      @(posedge clk); #2 reset = 1'b1;
      wait_done();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
